// File: rtl/loader_pkg.sv
// Shared definitions for the UART weight/bias loader: FSM states and header constants.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN2,
    S_LEN1,
    S_LEN0,
    S_PAYLOAD,
    S_DRAIN
  } load_state_e;

  localparam logic [7:0] MAGIC_BYTE = 8'hA5;
  localparam int         LEN_W_DEF  = 21;

endpackage

// File: rtl/word_skid_fifo.sv
// Synchronous word FIFO with registered read data, full/empty flags and a flush.
module word_skid_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_weight_loader.sv
// Parses a MAGIC + 24-bit length header from a UART byte stream, packs payload
// bytes into 16-bit words and forwards them to the HyperRAM write path.
module uart_weight_loader
  import loader_pkg::*;
#(
  parameter int         LEN_W       = LEN_W_DEF,
  parameter int         SKID_DEPTH  = 16,
  parameter logic [7:0] FIFO_HIGH   = 8'd240,
  parameter int         TIMEOUT_CYC = 5_000_000,
  parameter logic [7:0] MAGIC       = MAGIC_BYTE
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             uart_valid,
  input  logic [7:0]       uart_data,
  input  logic [7:0]       fifo_count,
  output logic             start_wr_hperram,
  output logic             wdata_tvalid,
  output logic [15:0]      wdata,
  output logic [LEN_W-1:0] file_length,
  output logic             length_valid,
  output logic             load_done,
  output logic             err_overflow,
  output logic             err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  load_state_e      state_q, state_d;
  logic [7:0]       len_b2, len_b1, lo_byte;
  logic [23:0]      len_full;
  logic [LEN_W-1:0] len_new;
  logic [LEN_W-1:0] word_cnt;
  logic             hi_phase;
  logic [TO_W-1:0]  to_cnt;
  logic             active, timeout_hit;
  logic             cap_b2, cap_b1, len_fire, lo_fire, push_fire, done_fire, abort;
  logic             vld_p0;
  logic [15:0]      word_p0;
  logic [7:0]       fifo_cnt_p0;
  logic             fifo_full, fifo_empty, pop;

  assign len_full    = {len_b2, len_b1, uart_data};
  assign len_new     = len_full[LEN_W-1:0];
  assign active      = state_q inside {S_LEN2, S_LEN1, S_LEN0, S_PAYLOAD};
  assign timeout_hit = active && (to_cnt == TO_W'(TIMEOUT_CYC));
  // Occupancy is the registered copy, so one extra word may follow a threshold crossing.
  assign pop         = !fifo_empty && (fifo_cnt_p0 < FIFO_HIGH) && !abort;

  always_comb begin
    state_d   = state_q;
    cap_b2    = 1'b0;
    cap_b1    = 1'b0;
    len_fire  = 1'b0;
    lo_fire   = 1'b0;
    push_fire = 1'b0;
    done_fire = 1'b0;
    abort     = 1'b0;
    if (timeout_hit) begin
      abort   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (uart_valid && uart_data == MAGIC) state_d = S_LEN2;
        S_LEN2:  if (uart_valid) begin cap_b2 = 1'b1; state_d = S_LEN1; end
        S_LEN1:  if (uart_valid) begin cap_b1 = 1'b1; state_d = S_LEN0; end
        S_LEN0: begin
          if (uart_valid) begin
            len_fire = 1'b1;
            state_d  = (len_new == '0) ? S_DRAIN : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (uart_valid && !hi_phase) begin
            lo_fire = 1'b1;
          end else if (uart_valid) begin
            push_fire = 1'b1;
            if (word_cnt + LEN_W'(1) == file_length) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Wait for the in-flight push as well as the buffer itself.
          if (fifo_empty && !vld_p0) begin
            done_fire = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      start_wr_hperram <= 1'b0;
      length_valid     <= 1'b0;
      load_done        <= 1'b0;
      wdata_tvalid     <= 1'b0;
      file_length      <= '0;
      err_overflow     <= 1'b0;
      err_timeout      <= 1'b0;
      word_cnt         <= '0;
      hi_phase         <= 1'b0;
      to_cnt           <= '0;
      vld_p0           <= 1'b0;
      fifo_cnt_p0      <= '0;
    end else begin
      length_valid <= len_fire;
      load_done    <= done_fire;
      vld_p0       <= push_fire;
      wdata_tvalid <= pop;
      fifo_cnt_p0  <= fifo_count;
      if (len_fire) begin
        file_length      <= len_new;
        start_wr_hperram <= 1'b1;
        word_cnt         <= '0;
        hi_phase         <= 1'b0;
      end
      if (lo_fire) hi_phase <= 1'b1;
      if (push_fire) begin
        word_cnt <= word_cnt + LEN_W'(1);
        hi_phase <= 1'b0;
      end
      if (done_fire) start_wr_hperram <= 1'b0;
      if (abort) begin
        start_wr_hperram <= 1'b0;
        err_timeout      <= 1'b1;
        hi_phase         <= 1'b0;
      end
      if (vld_p0 && fifo_full) err_overflow <= 1'b1;
      if (!active || uart_valid || abort) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (cap_b2)    len_b2  <= uart_data;
    if (cap_b1)    len_b1  <= uart_data;
    if (lo_fire)   lo_byte <= uart_data;
    if (push_fire) word_p0 <= {uart_data, lo_byte};
  end

  // Stage p0 -> buffer: packed word enters the skid FIFO one cycle after its odd byte.
  word_skid_fifo #(
    .WIDTH (16),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (ref_clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .wr_en   (vld_p0),
    .wr_data (word_p0),
    .rd_en   (pop),
    .rd_data (wdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_weight_loader.sv
// Randomised self-checking bench for uart_weight_loader with a byte-stream reference model.
module tb_uart_weight_loader;

  localparam int LEN_W = 21;
  localparam int TO    = 100;

  logic             ref_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             uart_valid = 1'b0;
  logic [7:0]       uart_data = 8'h00;
  logic [7:0]       fifo_count = 8'h00;
  logic             start_wr_hperram, wdata_tvalid, length_valid, load_done;
  logic             err_overflow, err_timeout;
  logic [15:0]      wdata;
  logic [LEN_W-1:0] file_length;

  uart_weight_loader #(
    .LEN_W       (LEN_W),
    .SKID_DEPTH  (16),
    .FIFO_HIGH   (8'd240),
    .TIMEOUT_CYC (TO),
    .MAGIC       (8'hA5)
  ) dut (
    .ref_clk          (ref_clk),
    .rst_n            (rst_n),
    .uart_valid       (uart_valid),
    .uart_data        (uart_data),
    .fifo_count       (fifo_count),
    .start_wr_hperram (start_wr_hperram),
    .wdata_tvalid     (wdata_tvalid),
    .wdata            (wdata),
    .file_length      (file_length),
    .length_valid     (length_valid),
    .load_done        (load_done),
    .err_overflow     (err_overflow),
    .err_timeout      (err_timeout)
  );

  always #5 ref_clk = ~ref_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;

  always @(posedge ref_clk) cyc <= cyc + 1;

  // Observed events
  logic [15:0] got_w[$];
  int          got_c[$];
  logic [15:0] exp_w[$];
  int          exp_c[$];
  int          lv_cnt, lv_cyc, ld_cnt, ld_cyc;
  logic [LEN_W-1:0] lv_len;
  logic        ld_start, ld_prev_start, prev_start;

  always begin
    @(posedge ref_clk);
    #1;
    if (wdata_tvalid) begin
      got_w.push_back(wdata);
      got_c.push_back(cyc);
    end
    if (length_valid) begin
      lv_cnt++;
      lv_cyc = cyc;
      lv_len = file_length;
    end
    if (load_done) begin
      ld_cnt++;
      ld_cyc = cyc;
      ld_start = start_wr_hperram;
      ld_prev_start = prev_start;
    end
    prev_start = start_wr_hperram;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_w.delete(); got_c.delete(); exp_w.delete(); exp_c.delete();
    lv_cnt = 0; lv_cyc = 0; ld_cnt = 0; ld_cyc = 0; lv_len = '0;
    ld_start = 1'b0; ld_prev_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge ref_clk);
    uart_valid = 1'b1;
    uart_data  = b;
    @(negedge ref_clk);
    uart_valid = 1'b0;
    last_cyc   = cyc;
  endtask

  task automatic send_header(input int len);
    logic [23:0] l;
    l = 24'(len);
    send_byte(8'hA5);
    send_byte(l[23:16]);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
  endtask

  task automatic send_words(input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      exp_w.push_back(w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      exp_c.push_back(last_cyc + 2);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (ld_cnt == 0 && k < budget) begin
      @(negedge ref_clk);
      k++;
    end
    repeat (2) @(negedge ref_clk);
    checks++;
    if (ld_cnt == 0) begin
      failures++;
      $display("FAIL %s load_done timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge ref_clk);
    checks++; if (start_wr_hperram !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", start_wr_hperram); end
    checks++; if (wdata_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", wdata_tvalid); end
    checks++; if (wdata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    checks++; if (file_length !== '0) begin failures++; $display("FAIL reset_len got=%0d exp=0", file_length); end
    checks++; if ({length_valid, load_done, err_overflow, err_timeout} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {length_valid, load_done, err_overflow, err_timeout});
    end
    rst_n = 1'b1;
    @(negedge ref_clk);
  endtask

  task automatic test_three_word();
    logic [7:0] pay [6];
    clear_mon();
    fifo_count = 8'd0;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_header(3);
    for (int i = 0; i < 6; i++) begin
      send_byte(pay[i]);
      if (i % 2 == 1) begin
        exp_w.push_back({pay[i], pay[i-1]});
        exp_c.push_back(last_cyc + 2);
      end
    end
    wait_done(50, "three_word");
    checks++; if (lv_cnt != 1 || lv_len !== 21'd3) begin failures++; $display("FAIL three_len got cnt=%0d len=%0d exp cnt=1 len=3", lv_cnt, lv_len); end
    checks++; if (got_w.size() != 3) begin failures++; $display("FAIL three_count got=%0d exp=3", got_w.size()); end
    for (int i = 0; i < 3 && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_c[i] != exp_c[i]) begin
        failures++; $display("FAIL three_word%0d got=%h@%0d exp=%h@%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
      end
    end
    checks++; if (ld_cnt != 1 || ld_start !== 1'b0 || ld_prev_start !== 1'b1) begin
      failures++; $display("FAIL three_done got cnt=%0d start=%b prev=%b exp cnt=1 start=0 prev=1", ld_cnt, ld_start, ld_prev_start);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    send_byte(8'h00);
    send_header(0);
    wait_done(20, "zero_len");
    checks++; if (lv_cnt != 1 || lv_len !== '0) begin failures++; $display("FAIL zero_len got cnt=%0d len=%0d exp cnt=1 len=0", lv_cnt, lv_len); end
    checks++; if (ld_cyc != lv_cyc + 1) begin failures++; $display("FAIL zero_gap got=%0d exp=1", ld_cyc - lv_cyc); end
    checks++; if (got_w.size() != 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", got_w.size()); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    fifo_count = 8'd245;
    send_header(10);
    send_words(10);
    repeat (20) @(negedge ref_clk);
    checks++; if (got_w.size() != 0) begin failures++; $display("FAIL bp_held got=%0d exp=0", got_w.size()); end
    fifo_count = 8'd0;
    wait_done(100, "bp");
    checks++; if (got_w.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", got_w.size()); end
    for (int i = 0; i < 10 && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_c[i] != got_c[0] + i) begin
        failures++; $display("FAIL bp_word%0d got=%h@%0d exp=%h@%0d", i, got_w[i], got_c[i], exp_w[i], got_c[0] + i);
      end
    end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL bp_overflow got=%b exp=0", err_overflow); end
  endtask

  task automatic test_overflow();
    clear_mon();
    fifo_count = 8'd255;
    send_header(20);
    send_words(20);
    repeat (5) @(negedge ref_clk);
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
    checks++; if (ld_cnt != 0) begin failures++; $display("FAIL ovf_early_done got=%0d exp=0", ld_cnt); end
    fifo_count = 8'd0;
    wait_done(100, "ovf");
    checks++; if (got_w.size() != 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", got_w.size()); end
    for (int i = 0; i < 16 && i < got_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] w;
    clear_mon();
    w = 16'($urandom);
    send_header(4);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(8'($urandom));
    repeat (TO + 10) @(negedge ref_clk);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", err_timeout); end
    checks++; if (start_wr_hperram !== 1'b0) begin failures++; $display("FAIL to_start got=%b exp=0", start_wr_hperram); end
    checks++; if (ld_cnt != 0) begin failures++; $display("FAIL to_done got=%0d exp=0", ld_cnt); end
    checks++; if (got_w.size() != 1 || (got_w.size() == 1 && got_w[0] !== w)) begin
      failures++; $display("FAIL to_words got=%0d exp=1 (%h)", got_w.size(), w);
    end
    clear_mon();
    send_header(1);
    send_words(1);
    wait_done(30, "to_reload");
    checks++; if (got_w.size() != 1 || (got_w.size() == 1 && got_w[0] !== exp_w[0])) begin
      failures++; $display("FAIL to_reload got=%0d words exp=1 (%h)", got_w.size(), exp_w[0]);
    end
    checks++; if (lv_len !== 21'd1) begin failures++; $display("FAIL to_reload_len got=%0d exp=1", lv_len); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_header(4);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    rst_n = 1'b0;
    @(negedge ref_clk);
    rst_n = 1'b1;
    checks++; if ({start_wr_hperram, wdata_tvalid, length_valid, load_done} !== 4'b0) begin
      failures++; $display("FAIL mid_ctrl got=%b exp=0000", {start_wr_hperram, wdata_tvalid, length_valid, load_done});
    end
    checks++; if (wdata !== 16'h0 || file_length !== '0) begin
      failures++; $display("FAIL mid_data got wdata=%h len=%0d exp 0", wdata, file_length);
    end
    checks++; if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL mid_err got=%b%b exp=00", err_overflow, err_timeout);
    end
    clear_mon();
    repeat (10) @(negedge ref_clk);
    checks++; if (got_w.size() != 0 || ld_cnt != 0) begin
      failures++; $display("FAIL mid_partial got words=%0d done=%0d exp 0", got_w.size(), ld_cnt);
    end
  endtask

  initial begin
    clear_mon();
    prev_start = 1'b0;
    test_reset();
    test_three_word();
    test_zero_len();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
